// File: rtl/gpr_pkg.sv
// Shared constants for the GPR writeback slice: default sizes and pending-counter encoding.
package gpr_pkg;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_NUM        = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << CNT_W) - 1);

endpackage : gpr_pkg

// File: rtl/gpr_wb_fifo.sv
// Load-return queue: registered storage, power-of-two depth, flags derived from the registered count.
module gpr_wb_fifo #(
  parameter int unsigned DW    = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : gpr_wb_fifo

// File: rtl/gpr_writeback.sv
// GPR writeback: arbitrates ALU results against queued load returns onto one register-file
// write port, and tracks per-register pending writes for source-busy checks.
module gpr_writeback
  import gpr_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned NUM        = DEF_NUM,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    alu_valid,
  input  logic [$clog2(NUM)-1:0]  alu_rd,
  input  logic [WIDTH-1:0]        alu_data,
  input  logic                    lsu_valid,
  input  logic [$clog2(NUM)-1:0]  lsu_rd,
  input  logic [WIDTH-1:0]        lsu_data,
  output logic                    lsu_ready,
  input  logic                    issue_valid,
  input  logic [$clog2(NUM)-1:0]  issue_rd,
  output logic                    issue_full,
  input  logic [$clog2(NUM)-1:0]  rs1,
  input  logic [$clog2(NUM)-1:0]  rs2,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [$clog2(NUM)-1:0]  addr_w,
  output logic [WIDTH-1:0]        data_w,
  output logic                    err
);

  localparam int unsigned AW   = $clog2(NUM);
  localparam int unsigned EW   = AW + WIDTH;
  localparam int unsigned NREG = 1 << AW;

  logic          q_push;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;
  logic [EW-1:0] q_head;
  logic          alu_sel;

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;
  logic             err_hit;

  // Results to r0 are acknowledged but never enter the queue.
  assign lsu_ready = !q_full;
  assign q_push    = lsu_valid && !q_full && (lsu_rd != '0);
  assign alu_sel   = alu_valid && (alu_rd != '0);
  assign q_pop     = !alu_sel && !q_empty;

  gpr_wb_fifo #(
    .DW    (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (q_push),
    .push_data ({lsu_rd, lsu_data}),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Write port: ALU has fixed priority, the queue head drains on ALU-idle cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_w <= '0;
      data_w <= '0;
    end else if (alu_sel) begin
      addr_w <= alu_rd;
      data_w <= alu_data;
    end else if (q_pop) begin
      addr_w <= q_head[EW-1:WIDTH];
      data_w <= q_head[WIDTH-1:0];
    end else begin
      addr_w <= '0;
      data_w <= '0;
    end
  end

  assign issue_full = issue_valid && (cnt[issue_rd] == CNT_MAX);
  assign rs1_busy   = (cnt[rs1] != '0);
  assign rs2_busy   = (cnt[rs2] != '0);

  // Per-register increment/decrement requests; r0 and unused indices never move.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    err_hit = 1'b0;
    for (int unsigned i = 1; i < NUM; i++) begin
      inc_vec[i] = issue_valid && !issue_full && (issue_rd == AW'(i));
      dec_vec[i] = (addr_w == AW'(i));
      if (dec_vec[i] && !inc_vec[i] && (cnt[i] == '0)) begin
        err_hit = 1'b1;
      end
    end
  end

  // Issue never pushes past CNT_MAX because issue_full gates inc_vec.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (err_hit) begin
      err <= 1'b1;
    end
  end

endmodule : gpr_writeback

// File: doc/gpr_writeback.md
GPR_WRITEBACK -- requirements
Module: gpr_writeback

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of the register file.
REQ-002 SHALL have parameter NUM, default 32, number of registers; register 0 is hardwired zero.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of entries in the load-return queue; power of two, at least 2.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports alu_valid, alu_rd, alu_data  input  1, $clog2(NUM), WIDTH  single-cycle result; no backpressure.
REQ-007 SHALL have ports lsu_valid, lsu_rd, lsu_data  input  1, $clog2(NUM), WIDTH  load or multi-cycle result.
REQ-008 SHALL have port lsu_ready  output  1  load-return queue can accept an entry.
REQ-009 SHALL have ports issue_valid, issue_rd  input  1, $clog2(NUM)  instruction issued that will write issue_rd.
REQ-010 SHALL have port issue_full  output  1  pending count of issue_rd is saturated; the issue is refused.
REQ-011 SHALL have ports rs1, rs2  input  $clog2(NUM) each  source registers to check.
REQ-012 SHALL have ports rs1_busy, rs2_busy  output  1 each  source has a write still outstanding.
REQ-013 SHALL have ports addr_w, data_w  output  $clog2(NUM), WIDTH  register-file write port; addr_w = 0 means no write.
REQ-014 SHALL have port err  output  1  sticky flag: a write was committed to a register with pending count 0.

Function
REQ-015 Arbitration: an ALU write with alu_valid=1 and alu_rd≠0 SHALL win the write port. Otherwise, if the queue is non-empty, the queue head SHALL be popped and written.
REQ-016 addr_w and data_w SHALL be registered: a request selected in cycle N appears on addr_w/data_w in cycle N+1. addr_w SHALL be 0 in any cycle with nothing selected.
REQ-017 Queue push SHALL occur when lsu_valid, lsu_ready and lsu_rd≠0 are all 1. A result with lsu_rd=0 SHALL be accepted and discarded.
REQ-018 lsu_ready SHALL equal "queue not full", based on the registered count only. There is no pass-through: when full, a same-cycle pop does not raise lsu_ready.
REQ-019 Simultaneous push and pop SHALL leave the occupancy unchanged and preserve FIFO order. Queue pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 Each register 1..NUM-1 SHALL have a 2-bit pending counter (values 0..3).
  - Counter increments on issue_valid=1, issue_rd≠0 and issue_full=0.
  - Counter decrements at the rising edge that ends a cycle with addr_w equal to that register.
REQ-021 issue_full SHALL be combinational and equal "issue_valid=1 and count[issue_rd]=3". When issue_full=1 the counter SHALL NOT change.
REQ-022 Increment and decrement of the same register in one cycle SHALL leave its counter unchanged.
REQ-023 A decrement of a counter that is 0 SHALL leave it at 0 and set err. err SHALL be cleared only by reset.
REQ-024 rs1_busy and rs2_busy SHALL be combinational and equal "count[rsX]≠0". Register 0 SHALL never be busy.
REQ-025 An ALU request that loses nothing is never delayed. A queued entry SHALL wait, without bound, while ALU writes continue.

Reset
REQ-026 Reset assertion SHALL immediately, and asynchronously, set all of the following:
  - addr_w=0, data_w=0;
  - all pending counters to 0;
  - queue empty (lsu_ready=1);
  - err=0.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries and pending counts; no write SHALL appear on addr_w in the cycle after reset deasserts.

Structure
REQ-028 The shared package gpr_pkg SHALL hold the default WIDTH, NUM and FIFO_DEPTH constants, and the pending-counter width constant (2).
REQ-029 The load-return queue SHALL be a sub-module gpr_wb_fifo with push/pop/full/empty ports and registered storage. Arbitration and the scoreboard SHALL stay in gpr_writeback.

Verification
REQ-030 ALU write: issue_rd=5, then alu_valid with alu_rd=5, alu_data=0xDEADBEEF -> addr_w=5, data_w=0xDEADBEEF one cycle later; rs1=5 busy until the following edge, then rs1_busy=0.
REQ-031 Contention: alu_valid (rd=3) and queued LSU (rd=7) present together -> addr_w=3 first, addr_w=7 in the next idle-ALU cycle.
REQ-032 Full queue: push 4 LSU results with the ALU continuously busy -> lsu_ready=0 after the 4th push. One idle ALU cycle -> lsu_ready=1 the cycle after the pop, and order is preserved.
REQ-033 Saturation: issue rd=9 four times -> the 4th cycle has issue_full=1 and count stays 3; three writes to rd=9 -> rs2=9 reads busy=0.
REQ-034 Error and zero handling:
  - a write to rd=12 with no prior issue -> err=1, which stays set;
  - lsu_rd=0 results -> never appear on addr_w.
REQ-035 Reset mid-operation: reset with 2 queued entries and pending counts -> lsu_ready=1, all busy=0, addr_w=0 after deassert.
